mem_dump_ctrl: RTL and testbench

- Parametrised debug engine that scans a contiguous window of data memory while the core is held off.
- DUMP mode streams each word out over a valid/ready channel; FILL mode writes words arriving on an input stream into memory.
- Replaces bench-only memory printing and preloading with a synthesisable block.
- Sits between the core's data-memory port mux and a debug host.

---
 rtl/mem_dump_pkg.sv | 21 ++
 rtl/mem_dump_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_dump_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_dump_pkg.sv
// rtl/mem_dump_pkg.sv - shared states, mode encodings and default widths for mem_dump_ctrl
package mem_dump_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HALT   = 3'd1,
      RD     = 3'd2,
      CAP    = 3'd3,
      EMIT   = 3'd4,
      WR     = 3'd5,
      FINISH = 3'd6
   } state_e;

   localparam logic MODE_DUMP = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_LEN_W  = 17;

endpackage

// File: rtl/mem_dump_ctrl.sv
// rtl/mem_dump_ctrl.sv - debug engine that dumps or fills a window of data memory
// Optional XOR checksum of transferred words: define MEM_DUMP_CHECKSUM_EN.
module mem_dump_ctrl
   import mem_dump_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int LEN_W  = DEF_LEN_W
)(
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic              mode,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              halt_req,
   input  logic              halt_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [DATA_W-1:0] out_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data
`ifdef MEM_DUMP_CHECKSUM_EN
   ,
   output logic [DATA_W-1:0] checksum
`endif
);

   state_e            state_q;
   logic              mode_q;
   logic [ADDR_W-1:0] cur_q, cur_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [DATA_W-1:0] odata_q;
   logic [ADDR_W-1:0] oaddr_q;
   logic              last_word;
   logic              emit_fire;
   logic              wr_fire;

   // cur wraps naturally at 2^ADDR_W, so a full-length window visits every word once.
   assign cur_d     = cur_q + ADDR_W'(1);
   assign rem_d     = rem_q - LEN_W'(1);
   assign last_word = (rem_q == LEN_W'(1));

   // abort outranks a same-cycle handshake: the word is neither consumed nor written.
   assign emit_fire = (state_q == EMIT) && out_ready && !abort;
   assign wr_fire   = (state_q == WR) && in_valid && !abort;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         mode_q  <= MODE_DUMP;
         cur_q   <= '0;
         rem_q   <= '0;
         odata_q <= '0;
         oaddr_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  mode_q  <= mode;
                  cur_q   <= start_addr;
                  rem_q   <= length;
                  state_q <= HALT;
               end
            end
            HALT: begin
               if (abort)
                  state_q <= FINISH;
               else if (halt_ack) begin
                  if (rem_q == '0)
                     state_q <= FINISH;
                  else
                     state_q <= (mode_q == MODE_FILL) ? WR : RD;
               end
            end
            RD: state_q <= abort ? FINISH : CAP;
            CAP: begin
               odata_q <= mem_rdata;
               oaddr_q <= cur_q;
               state_q <= abort ? FINISH : EMIT;
            end
            EMIT: begin
               if (abort)
                  state_q <= FINISH;
               else if (emit_fire) begin
                  cur_q   <= cur_d;
                  rem_q   <= rem_d;
                  state_q <= last_word ? FINISH : RD;
               end
            end
            WR: begin
               if (abort)
                  state_q <= FINISH;
               else if (wr_fire) begin
                  cur_q   <= cur_d;
                  rem_q   <= rem_d;
                  if (last_word)
                     state_q <= FINISH;
               end
            end
            FINISH:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy      = (state_q != IDLE);
   assign halt_req  = busy;
   assign done      = (state_q == FINISH);
   assign out_valid = (state_q == EMIT);
   assign out_addr  = oaddr_q;
   assign out_data  = odata_q;
   assign in_ready  = (state_q == WR);
   assign mem_en    = (state_q == RD) || wr_fire;
   assign mem_we    = wr_fire;
   assign mem_addr  = cur_q;
   assign mem_wdata = wr_fire ? in_data : '0;

`ifdef MEM_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         csum_q <= '0;
      else if ((state_q == IDLE) && start)
         csum_q <= '0;
      else if (emit_fire)
         csum_q <= csum_q ^ odata_q;
      else if (wr_fire)
         csum_q <= csum_q ^ in_data;
   end

   assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// tb/tb_mem_dump_ctrl.sv - directed self-checking bench for mem_dump_ctrl
module tb_mem_dump_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start = 1'b0, mode = 1'b0, abort = 1'b0;
   logic [15:0] start_addr = '0;
   logic [16:0] length = '0;
   logic        busy, done, halt_req, halt_ack;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        out_valid, out_ready = 1'b0;
   logic [15:0] out_addr;
   logic [31:0] out_data;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] in_data = '0;
`ifdef MEM_DUMP_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   always #5 CLK = ~CLK;

   mem_dump_ctrl dut (
      .CLK(CLK), .RST(RST), .start(start), .mode(mode), .start_addr(start_addr),
      .length(length), .abort(abort), .busy(busy), .done(done), .halt_req(halt_req),
      .halt_ack(halt_ack), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .out_valid(out_valid),
      .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data)
`ifdef MEM_DUMP_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [31:0] mem [0:65535];
   int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
   logic [15:0] beat_a [$];
   logic [31:0] beat_d [$];

   // Memory and host model sampled mid-cycle, where every DUT output is settled.
   always @(negedge CLK) begin
      halt_ack = halt_req;
      if (mem_en && !mem_we) begin
         rd_cnt++;
         mem_rdata = mem[mem_addr];
      end
      if (mem_en && mem_we) begin
         wr_cnt++;
         mem[mem_addr] = mem_wdata;
      end
      if (out_valid && out_ready && !abort) begin
         beat_a.push_back(out_addr);
         beat_d.push_back(out_data);
      end
      if (done) done_cnt++;
   end

   task automatic clear_counts();
      rd_cnt = 0; wr_cnt = 0; done_cnt = 0;
      beat_a.delete(); beat_d.delete();
   endtask

   task automatic do_start(input logic m, input logic [15:0] a, input logic [16:0] l);
      @(posedge CLK); #1;
      start = 1'b1; mode = m; start_addr = a; length = l;
      @(posedge CLK); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge CLK);
         seen = done;
      end
      chk(tag, seen, 1'b1);
      @(posedge CLK); #1;
   endtask

   task automatic wait_beats(input string tag, input int want);
      bit ok = 1'b0;
      for (int n = 0; n < 60 && !ok; n++) begin
         @(posedge CLK); #1;
         ok = (beat_a.size() == want);
      end
      chk(tag, ok, 1'b1);
   endtask

   task automatic wait_valid(input string tag);
      bit ok = 1'b0;
      for (int n = 0; n < 60 && !ok; n++) begin
         @(posedge CLK); #1;
         ok = out_valid;
      end
      chk(tag, ok, 1'b1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] fv [3];
      int          fi;
      int          rd0;
      bit          ok;

      for (int a = 0; a < 65536; a++) mem[a] = '0;
      for (int i = 0; i < 4; i++) mem[i] = 32'h1111_1111 * (i + 1);
      mem_rdata = '0;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_ctrl", {busy, done, halt_req, mem_en, mem_we, out_valid, in_ready}, 7'b0);
      chk("rst_data", {mem_addr, out_addr, out_data, mem_wdata}, 96'h0);
      RST = 1'b0;

      // DUMP of 4 words, with a start pulse while busy that must be ignored
      clear_counts();
      out_ready = 1'b1;
      do_start(1'b0, 16'h0000, 17'd4);
      do_start(1'b1, 16'h0100, 17'd2);
      wait_done("dump_done", 80);
      chk("dump_beats", beat_a.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("dump_addr%0d", i), beat_a[i], i);
         chk($sformatf("dump_data%0d", i), beat_d[i], 32'h1111_1111 * (i + 1));
      end
      chk("dump_reads", rd_cnt, 4);
      chk("dump_writes", wr_cnt, 0);
      chk("dump_done_cnt", done_cnt, 1);
      chk("dump_idle", {busy, halt_req}, 2'b00);

      // FILL of 3 words with in_valid toggling
      clear_counts();
      fv[0] = 32'hA; fv[1] = 32'hB; fv[2] = 32'hC;
      fi = 0;
      do_start(1'b1, 16'h0010, 17'd3);
      for (int c = 0; c < 60 && fi < 3; c++) begin
         @(posedge CLK); #1;
         in_valid = c[0];
         in_data  = fv[fi];
         @(negedge CLK);
         if (in_valid && in_ready) fi++;
      end
      @(posedge CLK); #1;
      in_valid = 1'b0;
      wait_done("fill_done", 20);
      chk("fill_m10", mem[16'h0010], 32'hA);
      chk("fill_m11", mem[16'h0011], 32'hB);
      chk("fill_m12", mem[16'h0012], 32'hC);
      chk("fill_m13", mem[16'h0013], 32'h0);
      chk("fill_writes", wr_cnt, 3);
      chk("fill_reads", rd_cnt, 0);
      chk("fill_done_cnt", done_cnt, 1);

      // Backpressure on the second beat
      clear_counts();
      mem[16'h0020] = 32'hA0A0_0001;
      mem[16'h0021] = 32'hA0A0_0002;
      mem[16'h0022] = 32'hA0A0_0003;
      out_ready = 1'b1;
      do_start(1'b0, 16'h0020, 17'd3);
      wait_beats("bp_first", 1);
      out_ready = 1'b0;
      wait_valid("bp_valid");
      rd0 = rd_cnt;
      repeat (5) @(posedge CLK);
      #1;
      chk("bp_hold_valid", out_valid, 1'b1);
      chk("bp_hold_addr", out_addr, 16'h0021);
      chk("bp_hold_data", out_data, 32'hA0A0_0002);
      chk("bp_no_reads", rd_cnt, rd0);
      out_ready = 1'b1;
      wait_done("bp_done", 40);
      chk("bp_beats", beat_a.size(), 3);
      chk("bp_data1", beat_d[1], 32'hA0A0_0002);
      chk("bp_data2", beat_d[2], 32'hA0A0_0003);
      chk("bp_reads", rd_cnt, 3);

      // Address wrap
      clear_counts();
      mem[16'hFFFE] = 32'hDEAD_0001;
      mem[16'hFFFF] = 32'hDEAD_0002;
      do_start(1'b0, 16'hFFFE, 17'd3);
      wait_done("wrap_done", 60);
      chk("wrap_beats", beat_a.size(), 3);
      chk("wrap_a0", beat_a[0], 16'hFFFE);
      chk("wrap_a1", beat_a[1], 16'hFFFF);
      chk("wrap_a2", beat_a[2], 16'h0000);
      chk("wrap_d2", beat_d[2], 32'h1111_1111);

      // Zero length
      clear_counts();
      do_start(1'b0, 16'h0050, 17'd0);
      wait_done("len0_done", 20);
      chk("len0_mem", rd_cnt + wr_cnt, 0);
      chk("len0_beats", beat_a.size(), 0);
      chk("len0_done_cnt", done_cnt, 1);

      // Abort on the second dump handshake
      clear_counts();
      out_ready = 1'b1;
      do_start(1'b0, 16'h0000, 17'd4);
      wait_beats("abort_first", 1);
      out_ready = 1'b0;
      wait_valid("abort_valid");
      abort = 1'b1;
      out_ready = 1'b1;
      @(posedge CLK); #1;
      abort = 1'b0;
      chk("abort_done", done, 1'b1);
      @(posedge CLK); #1;
      chk("abort_idle", busy, 1'b0);
      chk("abort_beats", beat_a.size(), 1);
      chk("abort_reads", rd_cnt, 2);
      chk("abort_done_cnt", done_cnt, 1);

      // Abort in IDLE does nothing
      abort = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      abort = 1'b0;
      chk("abort_idle_nop", {busy, done}, 2'b00);

      // Reset in the middle of a FILL
      clear_counts();
      in_valid = 1'b1;
      in_data = 32'h5555_5555;
      do_start(1'b1, 16'h0030, 17'd5);
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(posedge CLK); #1;
         ok = in_ready;
      end
      chk("rstfill_in_wr", ok, 1'b1);
      @(negedge CLK);
      #1;
      RST = 1'b1;
      #1;
      chk("rstfill_ctrl", {busy, done, halt_req, mem_en, mem_we, out_valid, in_ready}, 7'b0);
      chk("rstfill_data", {mem_addr, mem_wdata}, 48'h0);
      chk("rstfill_partial", mem[16'h0030], 32'h5555_5555);
      in_valid = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b0;

`ifdef MEM_DUMP_CHECKSUM_EN
      clear_counts();
      mem[16'h0040] = 32'h0F0F_0F0F;
      mem[16'h0041] = 32'hF0F0_F0F0;
      out_ready = 1'b1;
      do_start(1'b0, 16'h0040, 17'd2);
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge CLK);
         ok = done;
      end
      chk("csum_done", ok, 1'b1);
      chk("csum_value", checksum, 32'hFFFF_FFFF);
      @(posedge CLK); #1;
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
